// File: rtl/hockey_pkg.sv
// Shared types and constants for the air-hockey puck pipeline.
// The field geometry and colours are used by the mover and the collision block alike.
package hockey_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int COL_W     = 3;
    localparam int BOX       = 4;
    localparam int FIELD_MAX = 100;

    localparam logic [COL_W-1:0] COL_PUCK = 3'b111;
    localparam logic [COL_W-1:0] COL_BG   = 3'b000;

    typedef enum logic [2:0] {
        WAIT,
        ERASE,
        CHECK,
        MOVE,
        DRAW
    } state_t;

    // One-pixel step along an axis.
    // A step that would leave 0..FIELD_MAX-BOX is dropped, so the axis holds.
    function automatic int step_axis(input int pos, input logic inc);
        if (inc)
            return (pos < FIELD_MAX - BOX) ? pos + 1 : pos;
        else
            return (pos > 0) ? pos - 1 : pos;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Reloadable down-counter that marks the start of each movement frame.
// The counter holds at zero until the owner reloads it.
module frame_divider #(
    parameter int DIV = 833334
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic reload,
    output logic tick
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] TOP = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || reload)
            cnt <= TOP;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/puck_mover.sv
// Per-frame erase / collision-query / step / redraw sequencer for the 4x4 puck.
// Outputs are registered from the next state, so each plot lines up with its state cycle.
module puck_mover
    import hockey_pkg::*;
#(
    parameter int               FRAME_DIV   = 833334,
    parameter logic [X_W-1:0]   START_X     = 8'd10,
    parameter logic [Y_W-1:0]   START_Y     = 7'd20,
    parameter logic [COL_W-1:0] PUCK_COLOUR = COL_PUCK,
    parameter logic [COL_W-1:0] BG_COLOUR   = COL_BG
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             horizontal,
    input  logic             vertical,
    output logic             coll_enable,
    output logic [X_W-1:0]   box_x,
    output logic [Y_W-1:0]   box_y,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [COL_W-1:0] colour,
    output logic             plot
);
    state_t         state, nstate;
    logic [3:0]     pix, npix;
    logic [X_W-1:0] nbox_x, nx;
    logic [Y_W-1:0] nbox_y, ny;
    logic [COL_W-1:0] ncolour;
    logic           nplot, ncoll;
    logic           tick, reload;

    assign reload = (state == DRAW) && (pix == 4'd15);

    frame_divider #(.DIV(FRAME_DIV)) u_div (
        .clock  (clock),
        .reset  (reset_n),
        .en     (state == WAIT),
        .reload (reload),
        .tick   (tick)
    );

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset_n) begin
            state       <= WAIT;
            pix         <= '0;
            box_x       <= START_X;
            box_y       <= START_Y;
            plot        <= 1'b0;
            coll_enable <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            colour      <= BG_COLOUR;
        end else begin
            state       <= nstate;
            pix         <= npix;
            box_x       <= nbox_x;
            box_y       <= nbox_y;
            plot        <= nplot;
            coll_enable <= ncoll;
            x_out       <= nx;
            y_out       <= ny;
            colour      <= ncolour;
        end
    end

    // Next state, sweep counter and position
    always_comb begin
        nstate = state;
        npix   = pix;
        nbox_x = box_x;
        nbox_y = box_y;
        unique case (state)
            WAIT: begin
                if (tick) begin
                    nstate = ERASE;
                    npix   = '0;
                end
            end
            ERASE: begin
                npix = pix + 4'd1;
                if (pix == 4'd15) nstate = CHECK;
            end
            CHECK: nstate = MOVE;
            MOVE: begin
                // Flags were refreshed on the CHECK closing edge
                nbox_x = X_W'(step_axis(int'(box_x), horizontal));
                nbox_y = Y_W'(step_axis(int'(box_y), !vertical));
                nstate = DRAW;
                npix   = '0;
            end
            DRAW: begin
                npix = pix + 4'd1;
                if (pix == 4'd15) nstate = WAIT;
            end
            default: nstate = WAIT;
        endcase
    end

    // Output values for the cycle being entered
    always_comb begin
        nplot   = (nstate == ERASE) || (nstate == DRAW);
        ncoll   = (nstate == CHECK);
        ncolour = (nstate == DRAW) ? PUCK_COLOUR : BG_COLOUR;
        nx      = '0;
        ny      = '0;
        if (nplot) begin
            nx = nbox_x + X_W'(npix[1:0]);
            ny = nbox_y + Y_W'(npix[3:2]);
        end
    end

endmodule

// File: tb/tb_puck_mover.sv
// Directed bench for puck_mover with FRAME_DIV=40 and a scripted collision-flag model.
module tb_puck_mover;
    localparam int FD = 40;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       horizontal = 1'b1;
    logic       vertical = 1'b0;
    logic       coll_enable;
    logic [7:0] box_x;
    logic [6:0] box_y;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;

    int errors = 0;
    int checks = 0;

    puck_mover #(
        .FRAME_DIV   (FD),
        .START_X     (8'd10),
        .START_Y     (7'd20),
        .PUCK_COLOUR (3'b111),
        .BG_COLOUR   (3'b000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .horizontal  (horizontal),
        .vertical    (vertical),
        .coll_enable (coll_enable),
        .box_x       (box_x),
        .box_y       (box_y),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour      (colour),
        .plot        (plot)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
    endtask

    // Plays one frame; h1 replaces h0 just after the CHECK closing edge. Ends in WAIT.
    task automatic run_frame(input logic h0, input logic h1, input logic v0);
        int n;
        horizontal = h0;
        vertical   = v0;
        n = 0;
        while (!coll_enable && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!coll_enable) begin
            errors++;
            $display("FAIL frame_timeout: coll_enable not seen within %0d cycles", n);
        end
        @(posedge clock);
        #1 horizontal = h1;
        repeat (18) @(negedge clock);
    endtask

    task automatic test_reset();
        int n, bad;
        horizontal = 1'b1;
        vertical   = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({plot, coll_enable, x_out, y_out, colour, box_x, box_y} !==
            {1'b0, 1'b0, 8'd0, 7'd0, 3'b000, 8'd10, 7'd20}) begin
            errors++;
            $display("FAIL reset_state: plot=%b coll=%b x=%0d y=%0d col=%b box=(%0d,%0d) need 0 0 0 0 000 (10,20)",
                     plot, coll_enable, x_out, y_out, colour, box_x, box_y);
        end
        reset_n = 1'b0;
        n = 0;
        bad = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (plot) break;
            if (coll_enable || box_x !== 8'd10 || box_y !== 7'd20) bad++;
        end
        checks++;
        if (n !== FD) begin
            errors++;
            $display("FAIL first_tick: first plot after %0d cycles, need %0d", n, FD);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wait_quiet: %0d bad WAIT cycles, need 0", bad);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            checks++;
            if (plot !== 1'b1 || colour !== 3'b000 || x_out !== 8'(10 + i % 4) || y_out !== 7'(20 + i / 4)) begin
                errors++;
                $display("FAIL erase_px%0d: plot=%b col=%b at (%0d,%0d), need 1 000 at (%0d,%0d)",
                         i, plot, colour, x_out, y_out, 10 + i % 4, 20 + i / 4);
            end
        end
    endtask

    // Continues straight from the last erase pixel of test_reset.
    task automatic test_frame();
        int pulses;
        pulses = 0;
        @(negedge clock);
        if (coll_enable) pulses++;
        checks++;
        if (coll_enable !== 1'b1 || plot !== 1'b0 || box_x !== 8'd10 || box_y !== 7'd20) begin
            errors++;
            $display("FAIL check_cycle: coll=%b plot=%b box=(%0d,%0d), need 1 0 (10,20)", coll_enable, plot, box_x, box_y);
        end
        @(negedge clock);
        if (coll_enable) pulses++;
        checks++;
        if (coll_enable !== 1'b0 || plot !== 1'b0 || box_x !== 8'd10) begin
            errors++;
            $display("FAIL move_cycle: coll=%b plot=%b box_x=%0d, need 0 0 10", coll_enable, plot, box_x);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (coll_enable) pulses++;
            checks++;
            if (plot !== 1'b1 || colour !== 3'b111 || x_out !== 8'(11 + i % 4) || y_out !== 7'(21 + i / 4)) begin
                errors++;
                $display("FAIL draw_px%0d: plot=%b col=%b at (%0d,%0d), need 1 111 at (%0d,%0d)",
                         i, plot, colour, x_out, y_out, 11 + i % 4, 21 + i / 4);
            end
        end
        checks++;
        if (pulses !== 1 || box_x !== 8'd11 || box_y !== 7'd21) begin
            errors++;
            $display("FAIL frame_result: pulses=%0d box=(%0d,%0d), need 1 (11,21)", pulses, box_x, box_y);
        end
    endtask

    // Continues from the last DRAW pixel; three frames of gap and plot-pattern checks.
    task automatic test_back_to_back();
        int gap, bad;
        for (int f = 0; f < 3; f++) begin
            gap = 0;
            @(negedge clock);
            while (!plot && gap < 1000) begin
                gap++;
                @(negedge clock);
            end
            checks++;
            if (gap !== FD) begin
                errors++;
                $display("FAIL frame_gap%0d: %0d idle cycles, need %0d", f, gap, FD);
            end
            bad = 0;
            for (int c = 2; c <= 34; c++) begin
                @(negedge clock);
                if (plot !== ((c <= 16) || (c >= 19))) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL plot_pattern%0d: %0d wrong cycles, need 0", f, bad);
            end
        end
        checks++;
        if (box_x !== 8'd14 || box_y !== 7'd24) begin
            errors++;
            $display("FAIL after_3_frames: box=(%0d,%0d), need (14,24)", box_x, box_y);
        end
    endtask

    task automatic test_left_wall();
        apply_reset();
        for (int f = 0; f < 10; f++) run_frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (box_x !== 8'd0 || box_y !== 7'd30) begin
            errors++;
            $display("FAIL reach_left: box=(%0d,%0d), need (0,30)", box_x, box_y);
        end
        run_frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (box_x !== 8'd0) begin
            errors++;
            $display("FAIL left_saturate: box_x=%0d, need 0", box_x);
        end
        run_frame(1'b0, 1'b1, 1'b0);
        checks++;
        if (box_x !== 8'd1 || box_y !== 7'd32) begin
            errors++;
            $display("FAIL left_bounce: box=(%0d,%0d), need (1,32)", box_x, box_y);
        end
    endtask

    task automatic test_right_wall();
        apply_reset();
        for (int f = 0; f < 86; f++) run_frame(1'b1, 1'b1, 1'(f % 2));
        checks++;
        if (box_x !== 8'd96 || box_y !== 7'd20) begin
            errors++;
            $display("FAIL reach_right: box=(%0d,%0d), need (96,20)", box_x, box_y);
        end
        run_frame(1'b1, 1'b1, 1'b0);
        checks++;
        if (box_x !== 8'd96 || box_y !== 7'd21) begin
            errors++;
            $display("FAIL right_saturate: box=(%0d,%0d), need (96,21)", box_x, box_y);
        end
    endtask

    task automatic test_reset_mid_erase();
        int n, bad;
        apply_reset();
        run_frame(1'b1, 1'b1, 1'b0);
        n = 0;
        while (!plot && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (6) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (plot !== 1'b0 || coll_enable !== 1'b0 || box_x !== 8'd10 || box_y !== 7'd20) begin
            errors++;
            $display("FAIL mid_erase_reset: plot=%b coll=%b box=(%0d,%0d), need 0 0 (10,20)", plot, coll_enable, box_x, box_y);
        end
        reset_n = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (plot) break;
        end
        checks++;
        if (n !== FD) begin
            errors++;
            $display("FAIL restart_tick: first plot after %0d cycles, need %0d", n, FD);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            if (plot !== 1'b1 || colour !== 3'b000 || x_out !== 8'(10 + i % 4) || y_out !== 7'(20 + i / 4)) bad++;
        end
        @(negedge clock);
        checks++;
        if (bad !== 0 || plot !== 1'b0 || coll_enable !== 1'b1) begin
            errors++;
            $display("FAIL restart_erase: %0d bad pixels, then plot=%b coll=%b, need 0 then 0 1", bad, plot, coll_enable);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_left_wall();
        test_right_wall();
        test_reset_mid_erase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
